hyst_ctrl: RTL and testbench

- Parametrised successor to the single-channel temperature hysteresis controller.
- Takes a qualified W-bit temperature sample stream, runtime-programmable set/clear thresholds and an operating mode, and drives mutually exclusive cool and heat outputs.
- Enforces minimum-on and minimum-off dwell times to protect the actuator, and flags inconsistent threshold configuration.
- Sits between the sensor front-end and the actuator driver.

---
 rtl/hyst_pkg.sv | 33 +++
 rtl/hyst_ctrl_dwell_timer.sv | 40 ++++
 rtl/hyst_ctrl.sv | 129 ++++++++++++
 tb/tb_hyst_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hyst_pkg.sv
// rtl/hyst_pkg.sv - shared encodings and parameter checks for the hysteresis controller
package hyst_pkg;

  // FSM state encoding, also exported on the st port
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COOL = 2'd1,
    ST_HEAT = 2'd2,
    ST_REST = 2'd3
  } state_t;

  // Operating mode encoding
  localparam logic [1:0] MODE_OFF       = 2'd0;
  localparam logic [1:0] MODE_COOL_ONLY = 2'd1;
  localparam logic [1:0] MODE_HEAT_ONLY = 2'd2;
  localparam logic [1:0] MODE_AUTO      = 2'd3;

  // True when the mode lets the cool output run
  function automatic logic cool_allowed(input logic [1:0] mode);
    return (mode == MODE_COOL_ONLY) || (mode == MODE_AUTO);
  endfunction

  // True when the mode lets the heat output run
  function automatic logic heat_allowed(input logic [1:0] mode);
    return (mode == MODE_HEAT_ONLY) || (mode == MODE_AUTO);
  endfunction

  // Elaboration helper: value is representable in an unsigned counter of this width
  function automatic bit dwell_fits(input int value, input int width);
    return (value >= 0) && (width > 0) && (width < 31) && (value < (1 << width));
  endfunction

endpackage

// File: rtl/hyst_ctrl_dwell_timer.sv
// rtl/hyst_ctrl_dwell_timer.sv - saturating dwell counter with clear and limit compares
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [DWELL_W-1:0] limit,
  output logic               at,
  output logic               reached
);

  localparam logic [DWELL_W-1:0] CNT_MAX = '1;

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // Next count: clear on request, otherwise count up and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + DWELL_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at      = (count_q == limit);
  assign reached = (count_q >= limit);

endmodule

// File: rtl/hyst_ctrl.sv
// rtl/hyst_ctrl.sv - dual-output hysteresis controller with dwell protection
module hyst_ctrl
  import hyst_pkg::*;
#(
  parameter int W       = 8,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 32,
  parameter int DWELL_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sample,
  input  logic         sample_vld,
  input  logic [W-1:0] hi_set,
  input  logic [W-1:0] hi_clr,
  input  logic [W-1:0] lo_set,
  input  logic [W-1:0] lo_clr,
  input  logic [1:0]   mode,
  input  logic         en,
  output logic         cool_on,
  output logic         heat_on,
  output logic [1:0]   st,
  output logic         cfg_err
);

  if (!dwell_fits(MIN_ON, DWELL_W) || !dwell_fits(MIN_OFF, DWELL_W) || (MIN_OFF < 1))
  begin : g_bad_params
    $error("hyst_ctrl: MIN_ON/MIN_OFF must fit in DWELL_W bits and MIN_OFF must be >= 1");
  end

  // Compare points are count == N-1 because the count is 0 in the first cycle of a state
  localparam int ON_LIM_I  = (MIN_ON > 0) ? MIN_ON - 1 : 0;
  localparam int OFF_LIM_I = (MIN_OFF > 0) ? MIN_OFF - 1 : 0;
  localparam logic [DWELL_W-1:0] ON_LIM  = DWELL_W'(ON_LIM_I);
  localparam logic [DWELL_W-1:0] OFF_LIM = DWELL_W'(OFF_LIM_I);

  state_t             st_q, st_d;
  logic               cool_q, cool_d;
  logic               heat_q, heat_d;
  logic               cfg_err_q, cfg_err_d;
  logic [DWELL_W-1:0] dwell_limit;
  logic               dwell_at;
  logic               dwell_reached;
  logic               state_entry;

  // Threshold consistency: both bands must have hysteresis and must not overlap
  always_comb begin
    cfg_err_d = 1'b0;
    if ((hi_clr >= hi_set) || (lo_clr <= lo_set) || (lo_clr >= hi_clr)) begin
      cfg_err_d = 1'b1;
    end
  end

  // Next state and next output drive; safety exits override the minimum-on dwell
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: begin
        if (sample_vld && en && !cfg_err_q) begin
          if ((sample >= hi_set) && cool_allowed(mode)) begin
            st_d = ST_COOL;
          end else if ((sample <= lo_set) && heat_allowed(mode)) begin
            st_d = ST_HEAT;
          end
        end
      end
      ST_COOL: begin
        if (!en || cfg_err_q || !cool_allowed(mode)) begin
          st_d = ST_REST;
        end else if (sample_vld && (sample <= hi_clr) && dwell_reached) begin
          st_d = ST_REST;
        end
      end
      ST_HEAT: begin
        if (!en || cfg_err_q || !heat_allowed(mode)) begin
          st_d = ST_REST;
        end else if (sample_vld && (sample >= lo_clr) && dwell_reached) begin
          st_d = ST_REST;
        end
      end
      ST_REST: begin
        if (dwell_at) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    cool_d = (st_d == ST_COOL);
    heat_d = (st_d == ST_HEAT);
  end

  // The single timer serves both dwell phases, so its limit follows the current state
  always_comb begin
    state_entry = (st_d != st_q);
    dwell_limit = (st_q == ST_REST) ? OFF_LIM : ON_LIM;
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (state_entry),
    .limit   (dwell_limit),
    .at      (dwell_at),
    .reached (dwell_reached)
  );

  // State, output drive and configuration flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= ST_IDLE;
      cool_q    <= 1'b0;
      heat_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      cool_q    <= cool_d;
      heat_q    <= heat_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cool_on = cool_q;
  assign heat_on = heat_q;
  assign st      = st_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_hyst_ctrl.sv
// tb/tb_hyst_ctrl.sv - scoreboard bench for hyst_ctrl with directed vectors
module tb_hyst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       sample_vld = 1'b0;
  logic [7:0] hi_set = 8'd90;
  logic [7:0] hi_clr = 8'd85;
  logic [7:0] lo_set = 8'd70;
  logic [7:0] lo_clr = 8'd75;
  logic [1:0] mode = 2'd3;
  logic       en = 1'b1;
  logic       cool_on;
  logic       heat_on;
  logic [1:0] st;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int         due;
    logic [1:0] st;
    logic       cool;
    logic       heat;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] C = 2'd1;
  localparam logic [1:0] H = 2'd2;
  localparam logic [1:0] R = 2'd3;

  hyst_ctrl #(
    .W       (8),
    .MIN_ON  (4),
    .MIN_OFF (3),
    .DWELL_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample     (sample),
    .sample_vld (sample_vld),
    .hi_set     (hi_set),
    .hi_clr     (hi_clr),
    .lo_set     (lo_set),
    .lo_clr     (lo_clr),
    .mode       (mode),
    .en         (en),
    .cool_on    (cool_on),
    .heat_on    (heat_on),
    .st         (st),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every expectation that has come due, half a cycle after the edge
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (st !== e.st || cool_on !== e.cool || heat_on !== e.heat || cfg_err !== e.err) begin
        errors++;
        $display("FAIL %s: got st=%0d cool=%0b heat=%0b err=%0b, want st=%0d cool=%0b heat=%0b err=%0b",
                 e.name, st, cool_on, heat_on, cfg_err, e.st, e.cool, e.heat, e.err);
      end
    end
  end

  // One stimulus cycle: drive sample, queue the outputs expected after the next edge
  task automatic cyc(input logic [7:0] s, input logic v, input logic [1:0] est,
                     input logic eerr, input string name);
    exp_t e;
    sample     = s;
    sample_vld = v;
    e.due  = edge_cnt + 1;
    e.st   = est;
    e.cool = (est == C);
    e.heat = (est == H);
    e.err  = eerr;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Immediate comparison used while reset is held
  task automatic chk_now(input string name);
    checks++;
    if (st !== I || cool_on !== 1'b0 || heat_on !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got st=%0d cool=%0b heat=%0b err=%0b, want all zero",
               name, st, cool_on, heat_on, cfg_err);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset_state");
    rst = 1'b1;

    // 1: below hi_set stays idle, hi_set exactly turns cool on
    cyc(8'd80, 1'b1, I, 1'b0, "t1_idle_80");
    cyc(8'd90, 1'b1, C, 1'b0, "t1_cool_90");

    // 2: minimum-on holds cool, then exit to REST for exactly 3 cycles
    cyc(8'd84, 1'b1, C, 1'b0, "t2_minon_hold0");
    cyc(8'd84, 1'b0, C, 1'b0, "t2_minon_hold1");
    cyc(8'd84, 1'b0, C, 1'b0, "t2_minon_hold2");
    cyc(8'd84, 1'b1, R, 1'b0, "t2_cool_exit");
    cyc(8'd84, 1'b1, R, 1'b0, "t2_rest0");
    cyc(8'd84, 1'b1, R, 1'b0, "t2_rest1");
    cyc(8'd84, 1'b1, I, 1'b0, "t2_rest_done");

    // 3: heat at lo_set, hot sample cannot jump to COOL, REST ignores samples
    cyc(8'd70, 1'b1, H, 1'b0, "t3_heat_70");
    cyc(8'd95, 1'b1, H, 1'b0, "t3_heat_hold0");
    cyc(8'd95, 1'b1, H, 1'b0, "t3_heat_hold1");
    cyc(8'd95, 1'b1, H, 1'b0, "t3_heat_hold2");
    cyc(8'd95, 1'b1, R, 1'b0, "t3_heat_exit");
    cyc(8'd95, 1'b1, R, 1'b0, "t3_rest0");
    cyc(8'd95, 1'b1, R, 1'b0, "t3_rest1");
    cyc(8'd95, 1'b1, I, 1'b0, "t3_rest_done");
    cyc(8'd95, 1'b1, C, 1'b0, "t3_cool_after");

    // 4: en drop mid-dwell forces REST; sample=100 during REST ignored
    cyc(8'd95, 1'b0, C, 1'b0, "t4_cool_dwell");
    en = 1'b0;
    cyc(8'd95, 1'b0, R, 1'b0, "t4_en_drop");
    en = 1'b1;
    cyc(8'd100, 1'b1, R, 1'b0, "t4_rest0_ign");
    cyc(8'd100, 1'b1, R, 1'b0, "t4_rest1_ign");
    cyc(8'd100, 1'b1, I, 1'b0, "t4_rest_done");
    cyc(8'd100, 1'b1, C, 1'b0, "t4_cool_again");
    mode = 2'd2;
    cyc(8'd80, 1'b0, R, 1'b0, "t4_mode_heat_only");
    cyc(8'd80, 1'b0, R, 1'b0, "t4_mode_rest0");
    cyc(8'd80, 1'b0, R, 1'b0, "t4_mode_rest1");
    cyc(8'd80, 1'b0, I, 1'b0, "t4_mode_rest_done");
    cyc(8'd95, 1'b1, I, 1'b0, "t4_heat_only_no_cool");
    mode = 2'd3;

    // 5: misconfigured hi_clr flags, forces REST and blocks IDLE exit until restored
    cyc(8'd95, 1'b1, C, 1'b0, "t5_cool");
    hi_clr = 8'd92;
    cyc(8'd95, 1'b0, C, 1'b1, "t5_err_set");
    cyc(8'd95, 1'b0, R, 1'b1, "t5_err_exit");
    cyc(8'd95, 1'b1, R, 1'b1, "t5_rest0");
    cyc(8'd95, 1'b1, R, 1'b1, "t5_rest1");
    cyc(8'd95, 1'b1, I, 1'b1, "t5_rest_done");
    cyc(8'd95, 1'b1, I, 1'b1, "t5_idle_blocked");
    hi_clr = 8'd85;
    cyc(8'd95, 1'b1, I, 1'b0, "t5_err_clear");
    cyc(8'd95, 1'b1, C, 1'b0, "t5_resume");

    // 6: asynchronous reset between edges, then full-scale edge samples
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_now("t6_async_reset");
    @(posedge clk);
    #1;
    chk_now("t6_reset_hold");
    rst = 1'b1;
    cyc(8'd255, 1'b1, C, 1'b0, "t6_cool_255");
    cyc(8'd0, 1'b1, C, 1'b0, "t6_cool_hold0");
    cyc(8'd0, 1'b1, C, 1'b0, "t6_cool_hold1");
    cyc(8'd0, 1'b1, C, 1'b0, "t6_cool_hold2");
    cyc(8'd0, 1'b1, R, 1'b0, "t6_cool_exit_0");
    cyc(8'd0, 1'b1, R, 1'b0, "t6_rest0");
    cyc(8'd0, 1'b1, R, 1'b0, "t6_rest1");
    cyc(8'd0, 1'b1, I, 1'b0, "t6_rest_done");
    cyc(8'd0, 1'b1, H, 1'b0, "t6_heat_0");
    cyc(8'd255, 1'b1, H, 1'b0, "t6_heat_hold0");
    cyc(8'd255, 1'b1, H, 1'b0, "t6_heat_hold1");
    cyc(8'd255, 1'b1, H, 1'b0, "t6_heat_hold2");
    cyc(8'd255, 1'b1, R, 1'b0, "t6_heat_exit_255");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
